// File: rtl/phase_accumulator.sv
// Numerically controlled phase accumulator with glitch-free tuning-word updates.
// Stages: A = accumulator + tuning control, B = phase offset, C = quadrant/LUT fold.
module phase_accumulator #(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_load,
  input  logic [ACC_W-1:0]  phase_off,
  output logic [ACC_W-1:0]  phase,
  output logic [1:0]        quadrant,
  output logic [ADDR_W-1:0] lut_addr,
  output logic              sign,
  output logic              wrap,
  output logic              out_valid,
  output logic              ftw_pending
);

  generate
    if (ADDR_W + 2 > ACC_W) begin : g_bad_params
      $error("phase_accumulator: ADDR_W+2 must not exceed ACC_W");
    end
  endgenerate

  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_ftw_active;
  logic [ACC_W-1:0]  r_ftw_shadow;
  logic              r_pending;
  logic              r_wrap_a;
  logic              r_valid_a;
  logic [ACC_W-1:0]  r_phase_b;
  logic              r_wrap_b;
  logic              r_valid_b;
  logic [ACC_W-1:0]  r_phase;
  logic [1:0]        r_quadrant;
  logic [ADDR_W-1:0] r_lut_addr;
  logic              r_sign;
  logic              r_wrap;
  logic              r_out_valid;

  logic [ACC_W-1:0]  w_sum;
  logic [ACC_W:0]    w_c;
  logic              w_step;
  logic              w_wrap_a;
  logic              w_apply;
  logic [ADDR_W-1:0] w_fold_addr;

  // Ripple chain of full-adder cells: acc + ftw_active, carry-out is the wrap.
  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < ACC_W; i++) begin : g_fa
    assign w_sum[i]   = r_acc[i] ^ r_ftw_active[i] ^ w_c[i];
    assign w_c[i+1]   = (r_acc[i] & r_ftw_active[i]) |
                        (w_c[i] & (r_acc[i] ^ r_ftw_active[i]));
  end

  assign w_step   = en & ~clr;
  assign w_wrap_a = w_step & w_c[ACC_W];
  // A new tuning word may only take effect at a phase wrap or on clear.
  assign w_apply  = clr | w_wrap_a;

  assign w_fold_addr = r_phase_b[ACC_W-3 -: ADDR_W] ^ {ADDR_W{r_phase_b[ACC_W-2]}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_ftw_active <= '0;
      r_ftw_shadow <= '0;
      r_pending    <= 1'b0;
      r_wrap_a     <= 1'b0;
      r_valid_a    <= 1'b0;
      r_phase_b    <= '0;
      r_wrap_b     <= 1'b0;
      r_valid_b    <= 1'b0;
      r_phase      <= '0;
      r_quadrant   <= '0;
      r_lut_addr   <= '0;
      r_sign       <= 1'b0;
      r_wrap       <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      if (clr) begin
        r_acc <= '0;
      end else if (en) begin
        r_acc <= w_sum;
      end
      // Wrap/valid travel with the acc value they describe.
      r_wrap_a  <= w_wrap_a;
      r_valid_a <= w_step;

      if (ftw_load) begin
        r_ftw_shadow <= ftw_in;
        if (w_apply) begin
          r_ftw_active <= ftw_in;
          r_pending    <= 1'b0;
        end else begin
          r_pending    <= 1'b1;
        end
      end else if (w_apply && r_pending) begin
        r_ftw_active <= r_ftw_shadow;
        r_pending    <= 1'b0;
      end

      r_phase_b <= r_acc + phase_off;
      r_wrap_b  <= r_wrap_a;
      r_valid_b <= r_valid_a;

      r_phase     <= r_phase_b;
      r_quadrant  <= r_phase_b[ACC_W-1:ACC_W-2];
      r_sign      <= r_phase_b[ACC_W-1];
      r_lut_addr  <= w_fold_addr;
      r_wrap      <= r_wrap_b;
      r_out_valid <= r_valid_b;
    end
  end

  assign phase       = r_phase;
  assign quadrant    = r_quadrant;
  assign lut_addr    = r_lut_addr;
  assign sign        = r_sign;
  assign wrap        = r_wrap;
  assign out_valid   = r_out_valid;
  assign ftw_pending = r_pending;

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed bench for phase_accumulator (ACC_W=16, ADDR_W=6).
module tb_phase_accumulator;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [15:0] ftw_in;
  logic        ftw_load;
  logic [15:0] phase_off;
  logic [15:0] phase;
  logic [1:0]  quadrant;
  logic [5:0]  lut_addr;
  logic        sign;
  logic        wrap;
  logic        out_valid;
  logic        ftw_pending;

  int n_vec;
  int n_err;

  phase_accumulator #(.ACC_W(16), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .ftw_in     (ftw_in),
    .ftw_load   (ftw_load),
    .phase_off  (phase_off),
    .phase      (phase),
    .quadrant   (quadrant),
    .lut_addr   (lut_addr),
    .sign       (sign),
    .wrap       (wrap),
    .out_valid  (out_valid),
    .ftw_pending(ftw_pending)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 ns after the edge, outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en        = 1'b0;
    clr       = 1'b0;
    ftw_load  = 1'b0;
    ftw_in    = 16'h0000;
    phase_off = 16'h0000;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
  endtask

  task automatic load_clr(input logic [15:0] word);
    ftw_in   = word;
    ftw_load = 1'b1;
    clr      = 1'b1;
    tick();
    ftw_load = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({phase, quadrant, lut_addr, sign, wrap, out_valid, ftw_pending} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0",
               {phase, quadrant, lut_addr, sign, wrap, out_valid, ftw_pending});
    end
  endtask

  task automatic test_basic_step();
    logic [15:0] exp_ph;
    logic        exp_v;
    logic        exp_w;
    do_reset();
    load_clr(16'h1000);
    en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      exp_v  = (i >= 3);
      exp_w  = (i >= 18) && (((i - 2) % 16) == 0);
      exp_ph = (i >= 2) ? 16'((i - 2) * 16'h1000) : 16'h0000;
      n_vec++;
      if (out_valid !== exp_v) begin
        n_err++;
        $display("FAIL basic_valid i=%0d got=%b exp=%b", i, out_valid, exp_v);
      end
      n_vec++;
      if (phase !== exp_ph) begin
        n_err++;
        $display("FAIL basic_phase i=%0d got=%h exp=%h", i, phase, exp_ph);
      end
      n_vec++;
      if (wrap !== exp_w) begin
        n_err++;
        $display("FAIL basic_wrap i=%0d got=%b exp=%b", i, wrap, exp_w);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_quadrant_fold();
    logic [15:0] vals [0:5];
    logic [1:0]  quads[0:5];
    logic [5:0]  addrs[0:5];
    logic        signs[0:5];
    vals  = '{16'h0000, 16'h3F00, 16'h4000, 16'h4100, 16'h8000, 16'hC000};
    quads = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    addrs = '{6'd0, 6'd63, 6'd63, 6'd62, 6'd0, 6'd63};
    signs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      load_clr(vals[k]);
      en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      tick();
      n_vec++;
      if (phase !== vals[k]) begin
        n_err++;
        $display("FAIL fold_phase k=%0d got=%h exp=%h", k, phase, vals[k]);
      end
      n_vec++;
      if (quadrant !== quads[k]) begin
        n_err++;
        $display("FAIL fold_quad k=%0d got=%0d exp=%0d", k, quadrant, quads[k]);
      end
      n_vec++;
      if (lut_addr !== addrs[k]) begin
        n_err++;
        $display("FAIL fold_addr k=%0d got=%0d exp=%0d", k, lut_addr, addrs[k]);
      end
      n_vec++;
      if (sign !== signs[k]) begin
        n_err++;
        $display("FAIL fold_sign k=%0d got=%b exp=%b", k, sign, signs[k]);
      end
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL fold_valid k=%0d got=%b exp=1", k, out_valid);
      end
    end
  endtask

  task automatic test_glitch_free();
    logic [15:0] tab[0:16];
    logic        exp_p;
    tab = '{16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000, 16'h7000, 16'h8000,
            16'h9000, 16'hA000, 16'hB000, 16'hC000, 16'hD000, 16'hE000, 16'hF000,
            16'h0000, 16'h2000, 16'h4000};
    do_reset();
    load_clr(16'h1000);
    en = 1'b1;
    tick();
    tick();
    tick();
    ftw_in   = 16'h2000;
    ftw_load = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      tick();
      ftw_load = 1'b0;
      exp_p = (j < 12);
      n_vec++;
      if (ftw_pending !== exp_p) begin
        n_err++;
        $display("FAIL glitch_pending j=%0d got=%b exp=%b", j, ftw_pending, exp_p);
      end
      n_vec++;
      if (phase !== tab[j]) begin
        n_err++;
        $display("FAIL glitch_phase j=%0d got=%h exp=%h", j, phase, tab[j]);
      end
      n_vec++;
      if (wrap !== (j == 14)) begin
        n_err++;
        $display("FAIL glitch_wrap j=%0d got=%b exp=%b", j, wrap, (j == 14));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_coincident_load();
    logic [15:0] tab[0:4];
    tab = '{16'h8000, 16'hC000, 16'h0000, 16'h0800, 16'h1000};
    do_reset();
    load_clr(16'h4000);
    en = 1'b1;
    tick();
    tick();
    tick();
    ftw_in   = 16'h0800;
    ftw_load = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      ftw_load = 1'b0;
      n_vec++;
      if (ftw_pending !== 1'b0) begin
        n_err++;
        $display("FAIL coinc_pending k=%0d got=%b exp=0", k, ftw_pending);
      end
      n_vec++;
      if (phase !== tab[k]) begin
        n_err++;
        $display("FAIL coinc_phase k=%0d got=%h exp=%h", k, phase, tab[k]);
      end
      n_vec++;
      if (wrap !== (k == 2)) begin
        n_err++;
        $display("FAIL coinc_wrap k=%0d got=%b exp=%b", k, wrap, (k == 2));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_offset_clr();
    logic [15:0] tab_ph[0:6];
    logic        tab_v [0:6];
    tab_ph = '{16'h8100, 16'h8200, 16'h8300, 16'h8400, 16'h8000, 16'h8200, 16'h8400};
    tab_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    phase_off = 16'h8000;
    load_clr(16'h0100);
    en = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({phase, sign, quadrant, out_valid} !== {16'h8000, 1'b1, 2'd2, 1'b0}) begin
      n_err++;
      $display("FAIL offset_zero got=%h/%b/%0d/%b exp=8000/1/2/0",
               phase, sign, quadrant, out_valid);
    end
    ftw_in   = 16'h0200;
    ftw_load = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      ftw_load = 1'b0;
      clr      = (k == 1);
      if (k == 0) begin
        n_vec++;
        if (ftw_pending !== 1'b1) begin
          n_err++;
          $display("FAIL offset_pending_set got=%b exp=1", ftw_pending);
        end
      end
      if (k == 2) begin
        n_vec++;
        if (ftw_pending !== 1'b0) begin
          n_err++;
          $display("FAIL offset_pending_clr got=%b exp=0", ftw_pending);
        end
      end
      n_vec++;
      if (phase !== tab_ph[k]) begin
        n_err++;
        $display("FAIL offset_phase k=%0d got=%h exp=%h", k, phase, tab_ph[k]);
      end
      n_vec++;
      if (out_valid !== tab_v[k]) begin
        n_err++;
        $display("FAIL offset_valid k=%0d got=%b exp=%b", k, out_valid, tab_v[k]);
      end
      n_vec++;
      if (wrap !== 1'b0) begin
        n_err++;
        $display("FAIL offset_wrap k=%0d got=%b exp=0", k, wrap);
      end
    end
    clr = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_reset_hold();
    do_reset();
    load_clr(16'h5A00);
    en = 1'b1;
    tick();
    tick();
    tick();
    n_vec++;
    if (phase !== 16'h5A00) begin
      n_err++;
      $display("FAIL rstmid_pre got=%h exp=5a00", phase);
    end
    rst      = 1'b1;
    ftw_in   = 16'h1234;
    ftw_load = 1'b1;
    tick();
    rst      = 1'b0;
    ftw_load = 1'b0;
    en       = 1'b0;
    n_vec++;
    if ({phase, quadrant, lut_addr, sign, wrap, out_valid, ftw_pending} !== 28'h0) begin
      n_err++;
      $display("FAIL rstmid_flush got=%h exp=0",
               {phase, quadrant, lut_addr, sign, wrap, out_valid, ftw_pending});
    end
    // Hold with a non-zero accumulator.
    load_clr(16'h1000);
    en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if ({phase, out_valid, wrap} !== {16'h2000, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL hold k=%0d got=%h/%b/%b exp=2000/0/0", k, phase, out_valid, wrap);
      end
    end
    // Zero tuning word: accumulator stands still but steps stay valid.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    phase_off = 16'h1234;
    en        = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if ({phase, out_valid, wrap} !== {16'h1234, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL zero_ftw k=%0d got=%h/%b/%b exp=1234/1/0", k, phase, out_valid, wrap);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    en        = 1'b0;
    clr       = 1'b0;
    ftw_in    = 16'h0000;
    ftw_load  = 1'b0;
    phase_off = 16'h0000;
    test_reset();
    test_basic_step();
    test_quadrant_fold();
    test_glitch_free();
    test_coincident_load();
    test_offset_clr();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
